// File: rtl/pattern_match_counter.sv
// Counts rising edges of the 1101 detector output over fixed windows and publishes each window
// count on a valid/ready report port. Define PMC_STICKY_ALARM_EN to add alarm_clr/alarm_sticky.
module pattern_match_counter #(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_W      = 8,
    parameter int THRESH     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             match_in,
    input  logic             report_ready,
`ifdef PMC_STICKY_ALARM_EN
    input  logic             alarm_clr,
    output logic             alarm_sticky,
`endif
    output logic             report_valid,
    output logic [CNT_W-1:0] report_count,
    output logic             report_alarm,
    output logic             report_partial,
    output logic             overrun
);

    localparam int               WIN_W    = $clog2(WINDOW_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_q;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             alarm_q, alarm_d;
    logic             partial_q, partial_d;
    logic             overrun_q, overrun_d;

    logic             event_w;
    logic [CNT_W-1:0] cnt_inc;
    logic             close_w;
    logic             close_partial;
    logic             load_w;
    logic             drop_w;
    logic             alarm_new;

    // One count per detector S4 entry, saturating instead of wrapping.
    assign event_w   = match_in & ~match_q;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(event_w);
    assign alarm_new = (cnt_inc >= THRESH_V);

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        cnt_d         = cnt_q;
        close_w       = 1'b0;
        close_partial = 1'b0;
        case (state_q)
            ST_IDLE: begin
                win_d = '0;
                cnt_d = '0;
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) begin
                    close_w       = 1'b1;
                    close_partial = 1'b1;
                    state_d       = ST_IDLE;
                    win_d         = '0;
                    cnt_d         = '0;
                end else if (win_q == WIN_LAST) begin
                    close_w = 1'b1;
                    win_d   = '0;
                    cnt_d   = '0;
                end else begin
                    win_d = win_q + WIN_W'(1);
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Report handshake: report_* are held stable while report_valid is high and transfer on
    // report_valid & report_ready; a close may reload in that same cycle, otherwise it is dropped.
    assign load_w = close_w & (~valid_q | report_ready);
    assign drop_w = close_w & valid_q & ~report_ready;

    always_comb begin
        valid_d   = valid_q;
        count_d   = count_q;
        alarm_d   = alarm_q;
        partial_d = partial_q;
        if (load_w) begin
            valid_d   = 1'b1;
            count_d   = cnt_inc;
            alarm_d   = alarm_new;
            partial_d = close_partial;
        end else if (valid_q && report_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef PMC_STICKY_ALARM_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d  = sticky_q;
        overrun_d = overrun_q;
        if (load_w && alarm_new) sticky_d = 1'b1;
        else if (alarm_clr)      sticky_d = 1'b0;
        if (drop_w)         overrun_d = 1'b1;
        else if (alarm_clr) overrun_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) sticky_q <= 1'b0;
        else       sticky_q <= sticky_d;
    end

    assign alarm_sticky = sticky_q;
`else
    assign overrun_d = overrun_q | drop_w;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            win_q     <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            valid_q   <= 1'b0;
            count_q   <= '0;
            alarm_q   <= 1'b0;
            partial_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            match_q   <= match_in;
            valid_q   <= valid_d;
            count_q   <= count_d;
            alarm_q   <= alarm_d;
            partial_q <= partial_d;
            overrun_q <= overrun_d;
        end
    end

    assign report_valid   = valid_q;
    assign report_count   = count_q;
    assign report_alarm   = alarm_q;
    assign report_partial = partial_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_pattern_match_counter.sv
// Bench for pattern_match_counter: integer window model checked every cycle, directed scenarios
// with literal expectations, a narrow-counter instance for saturation, then random traffic.
module tb_pattern_match_counter;

    localparam int WL   = 16;
    localparam int CW   = 4;
    localparam int TH   = 3;
    localparam int MAXC = (1 << CW) - 1;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          match_in;
    logic          report_ready;
    logic          report_valid;
    logic [CW-1:0] report_count;
    logic          report_alarm;
    logic          report_partial;
    logic          overrun;
    logic          s_valid;
    logic [1:0]    s_count;
    logic          s_alarm;
    logic          s_partial;
    logic          s_overrun;
`ifdef PMC_STICKY_ALARM_EN
    logic          alarm_clr;
    logic          alarm_sticky;
    logic          s_sticky;
`endif

    int errors = 0;
    int checks = 0;
    logic [CW+1:0] got_q[$];

    always #5 clk = ~clk;

    pattern_match_counter #(.WINDOW_LEN(WL), .CNT_W(CW), .THRESH(TH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .match_in(match_in),
        .report_ready(report_ready),
`ifdef PMC_STICKY_ALARM_EN
        .alarm_clr(alarm_clr), .alarm_sticky(alarm_sticky),
`endif
        .report_valid(report_valid), .report_count(report_count),
        .report_alarm(report_alarm), .report_partial(report_partial), .overrun(overrun)
    );

    pattern_match_counter #(.WINDOW_LEN(WL), .CNT_W(2), .THRESH(3)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .match_in(match_in),
        .report_ready(report_ready),
`ifdef PMC_STICKY_ALARM_EN
        .alarm_clr(alarm_clr), .alarm_sticky(s_sticky),
`endif
        .report_valid(s_valid), .report_count(s_count),
        .report_alarm(s_alarm), .report_partial(s_partial), .overrun(s_overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window-level model: a running flag, a position, an integer count and the report slot.
    bit m_run, m_prev, m_valid, m_alarm, m_partial, m_overrun, m_sticky;
    int m_pos, m_cnt, m_count;

    always @(posedge clk) begin : model_p
        int  ev, total;
        bit  closed, part;
        if (reset) begin
            m_run = 0; m_pos = 0; m_cnt = 0; m_valid = 0; m_count = 0;
            m_alarm = 0; m_partial = 0; m_overrun = 0; m_sticky = 0;
        end else begin
            ev = (match_in && !m_prev) ? 1 : 0;
            closed = 0; part = 0; total = 0;
            if (m_run) begin
                total = (m_cnt + ev > MAXC) ? MAXC : m_cnt + ev;
                if (!enable) begin
                    closed = 1; part = 1; m_run = 0; m_pos = 0; m_cnt = 0;
                end else if (m_pos == WL - 1) begin
                    closed = 1; m_pos = 0; m_cnt = 0;
                end else begin
                    m_pos++; m_cnt = total;
                end
            end else if (enable) begin
                m_run = 1;
            end
`ifdef PMC_STICKY_ALARM_EN
            if (alarm_clr) begin m_sticky = 0; m_overrun = 0; end
`endif
            if (closed && m_valid && !report_ready) m_overrun = 1;
            if (closed && (!m_valid || report_ready)) begin
                m_valid = 1; m_count = total; m_alarm = (total >= TH); m_partial = part;
                if (total >= TH) m_sticky = 1;
            end else if (m_valid && report_ready) begin
                m_valid = 0;
            end
        end
        m_prev = reset ? 1'b0 : match_in;
    end

    always @(negedge clk) begin : compare_p
        int sc;
        sc = (m_count > SMAX) ? SMAX : m_count;
        chk("valid", report_valid, m_valid);
        chk("overrun", overrun, m_overrun);
        chk("sat_valid", s_valid, m_valid);
        chk("sat_overrun", s_overrun, m_overrun);
`ifdef PMC_STICKY_ALARM_EN
        chk("alarm_sticky", alarm_sticky, m_sticky);
`endif
        if (m_valid) begin
            chk("count", report_count, m_count);
            chk("alarm", report_alarm, m_alarm);
            chk("partial", report_partial, m_partial);
            chk("sat_count", s_count, sc);
            chk("sat_alarm", s_alarm, (sc >= 3));
            chk("sat_partial", s_partial, m_partial);
        end
        if (report_valid && report_ready)
            got_q.push_back({report_partial, report_alarm, report_count});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; match_in = 1'b0; report_ready = 1'b0;
`ifdef PMC_STICKY_ALARM_EN
        alarm_clr = 1'b0;
`endif
        tick();
        reset = 1'b0;
    endtask

    task automatic run_window(input logic [WL-1:0] pat);
        for (int i = 0; i < WL; i++) begin
            match_in = pat[i];
            tick();
        end
    endtask

    task automatic expect_entry(input string name, input int idx, input int cnt,
                                input int alm, input int part);
        logic [CW+1:0] e;
        if (idx >= got_q.size()) begin
            chk({name, "_present"}, got_q.size(), idx + 1);
        end else begin
            e = got_q[idx];
            chk({name, "_cnt"}, e[CW-1:0], cnt);
            chk({name, "_alarm"}, e[CW], alm);
            chk({name, "_partial"}, e[CW+1], part);
        end
    endtask

    initial begin
        logic [WL-1:0] pat;
        reset = 1'b1; enable = 1'b0; match_in = 1'b0; report_ready = 1'b0;
`ifdef PMC_STICKY_ALARM_EN
        alarm_clr = 1'b0;
`endif

        // Two pulses in window 0; report appears right after the 16th window cycle.
        do_reset();
        chk("rst_valid", report_valid, 0);
        chk("rst_count", report_count, 0);
        chk("rst_alarm", report_alarm, 0);
        chk("rst_partial", report_partial, 0);
        chk("rst_overrun", overrun, 0);
        enable = 1'b1;
        tick();
        pat = 16'h0108;
        for (int i = 0; i < WL - 1; i++) begin
            match_in = pat[i];
            tick();
        end
        chk("lat_early", report_valid, 0);
        match_in = pat[WL-1];
        tick();
        chk("w0_valid", report_valid, 1);
        chk("w0_count", report_count, 2);
        chk("w0_alarm", report_alarm, 0);
        chk("w0_partial", report_partial, 0);
        report_ready = 1'b1;
        tick();
        report_ready = 1'b0;
        tick();

        // Window boundary ownership of edges.
        do_reset();
        report_ready = 1'b1;
        got_q.delete();
        enable = 1'b1;
        tick();
        run_window(16'h8000);
        run_window(16'h0001);
        run_window(16'h0001);
        match_in = 1'b0; enable = 1'b0;
        repeat (3) tick();
        chk("bnd_size", got_q.size(), 4);
        expect_entry("bnd0", 0, 1, 0, 0);
        expect_entry("bnd1", 1, 0, 0, 0);
        expect_entry("bnd2", 2, 1, 0, 0);
        expect_entry("bnd3", 3, 0, 0, 1);

        // Held level counts once; eight edges saturate the narrow instance.
        do_reset();
        report_ready = 1'b1;
        got_q.delete();
        enable = 1'b1;
        tick();
        run_window(16'h007C);
        run_window(16'h5555);
        chk("edge8_count", report_count, 8);
        chk("sat_lit_count", s_count, 3);
        chk("sat_lit_alarm", s_alarm, 1);
        enable = 1'b0; match_in = 1'b0;
        repeat (3) tick();
        expect_entry("held", 0, 1, 0, 0);
        expect_entry("edge8", 1, 8, 1, 0);

        // Consumer stalls across two closes: first report held, second dropped.
        do_reset();
        enable = 1'b1;
        tick();
        run_window(16'h0055);
        chk("stall_count", report_count, 4);
        chk("stall_alarm", report_alarm, 1);
        chk("stall_ovr0", overrun, 0);
        run_window(16'h0005);
        chk("drop_valid", report_valid, 1);
        chk("drop_count", report_count, 4);
        chk("drop_ovr", overrun, 1);
        report_ready = 1'b1;
        enable = 1'b0; match_in = 1'b0;
        repeat (3) tick();
        chk("ovr_sticky", overrun, 1);

        // Early close by enable falling, then idle ignores pulses.
        do_reset();
        report_ready = 1'b1;
        got_q.delete();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            match_in = (i == 1 || i == 3 || i == 5);
            tick();
        end
        match_in = 1'b0; enable = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            match_in = i[0];
            tick();
        end
        chk("part_size", got_q.size(), 1);
        expect_entry("part", 0, 3, 1, 1);
        chk("idle_valid", report_valid, 0);

        // Reset mid-window with a report pending.
        do_reset();
        enable = 1'b1;
        tick();
        run_window(16'h0010);
        run_window(16'h0000);
        for (int i = 0; i < 6; i++) begin
            match_in = (i == 1 || i == 4);
            tick();
        end
        reset = 1'b1; enable = 1'b0; match_in = 1'b0;
        tick();
        chk("mrst_valid", report_valid, 0);
        chk("mrst_count", report_count, 0);
        chk("mrst_alarm", report_alarm, 0);
        chk("mrst_overrun", overrun, 0);
        reset = 1'b0; report_ready = 1'b1;
        got_q.delete();
        repeat (20) tick();
        chk("mrst_no_report", got_q.size(), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            match_in     = ($urandom_range(0, 2) == 0);
            enable       = ($urandom_range(0, 63) != 0);
            report_ready = ((i / 64) % 4 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 599) == 0);
`ifdef PMC_STICKY_ALARM_EN
            alarm_clr    = ($urandom_range(0, 31) == 0);
`endif
            tick();
        end
        reset = 1'b0; enable = 1'b0;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
